// File: rtl/mc14500_icu.sv
// MC14500B-style 1-bit industrial control unit: FETCH -> EXEC -> (WRITE) sequencer.
// Optional macro RTN_STACK_EN adds a one-entry return register used by JMP/RTN.
module mc14500_icu #(
    parameter int ADDR_W = 8,
    parameter int PC_W   = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    output logic [PC_W-1:0]   pc,
    input  logic [ADDR_W+3:0] instr,
    output logic [ADDR_W-1:0] ram_address,
    output logic              ram_write,
    output logic              ram_data_in,
    input  logic              ram_data_out,
    output logic              rr,
    output logic              flag_o,
    output logic              flag_f,
    output logic              jmp,
    output logic              rtn
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_EXEC  = 2'd1,
        S_WRITE = 2'd2
    } state_t;

    localparam logic [3:0] OP_NOPO = 4'h0, OP_LD  = 4'h1, OP_LDC = 4'h2, OP_AND  = 4'h3;
    localparam logic [3:0] OP_ANDC = 4'h4, OP_OR  = 4'h5, OP_ORC = 4'h6, OP_XNOR = 4'h7;
    localparam logic [3:0] OP_STO  = 4'h8, OP_STOC = 4'h9, OP_IEN = 4'hA, OP_OEN = 4'hB;
    localparam logic [3:0] OP_JMP  = 4'hC, OP_RTN = 4'hD, OP_SKZ = 4'hE, OP_NOPF = 4'hF;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [3:0]        r_opcode;
    logic [PC_W-1:0]   r_pc;
    logic [ADDR_W-1:0] r_ram_address;
    logic              r_ram_write;
    logic              r_ram_data_in;
    logic              r_rr;
    logic              r_ien;
    logic              r_oen;
    logic              r_skip;
    logic              r_flag_o;
    logic              r_flag_f;
    logic              r_jmp;
    logic              r_rtn;
    logic              w_active;
    logic              w_d;
    logic              w_skip_nxt;
    logic [PC_W-1:0]   w_pc_inc;
    logic [PC_W-1:0]   w_pc_nxt;
`ifdef RTN_STACK_EN
    logic [PC_W-1:0]   r_ret;
`endif

    // A skipped instruction still advances pc but touches nothing else.
    assign w_active = (r_state == S_EXEC) && !r_skip;
    assign w_d      = ram_data_out & r_ien;
    assign w_pc_inc = r_pc + PC_W'(1);

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = w_pc_inc;
        w_skip_nxt  = 1'b0;
        case (r_state)
            S_FETCH: if (enable) w_state_nxt = S_EXEC;
            S_EXEC: begin
                w_state_nxt = S_FETCH;
                if (w_active) begin
                    case (r_opcode)
                        OP_STO, OP_STOC: if (r_oen) w_state_nxt = S_WRITE;
                        OP_JMP:          w_pc_nxt = PC_W'(r_ram_address);
                        OP_RTN: begin
                            w_skip_nxt = 1'b1;
`ifdef RTN_STACK_EN
                            w_pc_nxt   = r_ret;
`endif
                        end
                        OP_SKZ:          w_skip_nxt = ~r_rr;
                        default:         ;
                    endcase
                end
            end
            S_WRITE: w_state_nxt = S_FETCH;
            default: w_state_nxt = S_FETCH;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state       <= S_FETCH;
            r_opcode      <= OP_NOPO;
            r_pc          <= '0;
            r_ram_address <= '0;
            r_ram_write   <= 1'b0;
            r_ram_data_in <= 1'b0;
            r_rr          <= 1'b0;
            r_ien         <= 1'b0;
            r_oen         <= 1'b0;
            r_skip        <= 1'b0;
            r_flag_o      <= 1'b0;
            r_flag_f      <= 1'b0;
            r_jmp         <= 1'b0;
            r_rtn         <= 1'b0;
`ifdef RTN_STACK_EN
            r_ret         <= '0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_ram_write <= (w_state_nxt == S_WRITE);
            r_flag_o    <= w_active && (r_opcode == OP_NOPO);
            r_flag_f    <= w_active && (r_opcode == OP_NOPF);
            r_jmp       <= w_active && (r_opcode == OP_JMP);
            r_rtn       <= w_active && (r_opcode == OP_RTN);
            if (r_state == S_FETCH && enable) begin
                r_opcode      <= instr[ADDR_W+3:ADDR_W];
                r_ram_address <= instr[ADDR_W-1:0];
            end
            if (r_state == S_EXEC) begin
                r_pc   <= w_pc_nxt;
                r_skip <= w_skip_nxt;
            end
            if (w_active) begin
                case (r_opcode)
                    OP_LD:   r_rr <= w_d;
                    OP_LDC:  r_rr <= ~w_d;
                    OP_AND:  r_rr <= r_rr & w_d;
                    OP_ANDC: r_rr <= r_rr & ~w_d;
                    OP_OR:   r_rr <= r_rr | w_d;
                    OP_ORC:  r_rr <= r_rr | ~w_d;
                    OP_XNOR: r_rr <= ~(r_rr ^ w_d);
                    OP_STO:  r_ram_data_in <= r_rr;
                    OP_STOC: r_ram_data_in <= ~r_rr;
                    OP_IEN:  r_ien <= ram_data_out;
                    OP_OEN:  r_oen <= ram_data_out;
`ifdef RTN_STACK_EN
                    OP_JMP:  r_ret <= w_pc_inc;
`endif
                    default: ;
                endcase
            end
        end
    end

    assign pc          = r_pc;
    assign ram_address = r_ram_address;
    assign ram_write   = r_ram_write;
    assign ram_data_in = r_ram_data_in;
    assign rr          = r_rr;
    assign flag_o      = r_flag_o;
    assign flag_f      = r_flag_f;
    assign jmp         = r_jmp;
    assign rtn         = r_rtn;

endmodule

// File: tb/tb_mc14500_icu.sv
// Bench for mc14500_icu: bench-side program/data memories and an instruction-level
// reference model; honours RTN_STACK_EN when compiled with it.
module tb_mc14500_icu;
    localparam int ADDR_W = 8;
    localparam int PC_W   = 8;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic              enable = 1'b0;
    logic [PC_W-1:0]   pc;
    logic [ADDR_W+3:0] instr;
    logic [ADDR_W-1:0] ram_address;
    logic              ram_write;
    logic              ram_data_in;
    logic              ram_data_out;
    logic              rr;
    logic              flag_o;
    logic              flag_f;
    logic              jmp;
    logic              rtn;

    logic [11:0] prog [256];
    logic        mem  [256];

    logic [7:0] m_pc;
    logic [7:0] m_ret;
    logic       m_rr;
    logic       m_ien;
    logic       m_oen;
    logic       m_skip;
    logic       m_din;
    logic       m_ram [256];

    int n_checks = 0;
    int n_fail   = 0;

    mc14500_icu #(.ADDR_W(ADDR_W), .PC_W(PC_W)) dut (
        .clock(clock), .reset(reset), .enable(enable), .pc(pc), .instr(instr),
        .ram_address(ram_address), .ram_write(ram_write), .ram_data_in(ram_data_in),
        .ram_data_out(ram_data_out), .rr(rr), .flag_o(flag_o), .flag_f(flag_f),
        .jmp(jmp), .rtn(rtn)
    );

    always #5 clock = ~clock;

    assign instr        = prog[pc];
    assign ram_data_out = mem[ram_address];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = 8'd0; m_ret = 8'd0; m_rr = 1'b0; m_ien = 1'b0;
        m_oen = 1'b0; m_skip = 1'b0; m_din = 1'b0;
    endtask

    task automatic set_mem(input int a, input logic v);
        mem[a]   = v;
        m_ram[a] = v;
    endtask

    // One instruction at ISA level; flags packed {flag_o, flag_f, jmp, rtn}.
    task automatic model_step(output logic [3:0] e_flags, output logic e_wr, output logic [7:0] e_opd);
        logic [3:0] op;
        logic [7:0] nxt;
        logic       raw;
        logic       d;
        op      = prog[m_pc][11:8];
        e_opd   = prog[m_pc][7:0];
        raw     = m_ram[e_opd];
        d       = raw & m_ien;
        nxt     = m_pc + 8'd1;
        e_flags = 4'b0;
        e_wr    = 1'b0;
        if (m_skip) begin
            m_skip = 1'b0;
        end else begin
            m_skip = 1'b0;
            case (op)
                4'h0: e_flags[3] = 1'b1;
                4'h1: m_rr = d;
                4'h2: m_rr = ~d;
                4'h3: m_rr = m_rr & d;
                4'h4: m_rr = m_rr & ~d;
                4'h5: m_rr = m_rr | d;
                4'h6: m_rr = m_rr | ~d;
                4'h7: m_rr = (m_rr == d);
                4'h8: begin m_din = m_rr;  e_wr = m_oen; end
                4'h9: begin m_din = ~m_rr; e_wr = m_oen; end
                4'hA: m_ien = raw;
                4'hB: m_oen = raw;
                4'hC: begin e_flags[1] = 1'b1; m_ret = nxt; nxt = e_opd; end
                4'hD: begin
                    e_flags[0] = 1'b1;
                    m_skip = 1'b1;
`ifdef RTN_STACK_EN
                    nxt = m_ret;
`endif
                end
                4'hE: m_skip = (m_rr == 1'b0);
                default: e_flags[2] = 1'b1;
            endcase
        end
        if (e_wr) m_ram[e_opd] = m_din;
        m_pc = nxt;
    endtask

    task automatic run_instr();
        logic [3:0] ef;
        logic       ew;
        logic [7:0] eo;
        if ($urandom_range(0, 4) == 0) begin
            enable = 1'b0;
            repeat ($urandom_range(1, 3)) begin
                @(posedge clock); @(negedge clock);
                check("stall_pc", 32'(pc), 32'(m_pc));
            end
        end
        check("fetch_pc", 32'(pc), 32'(m_pc));
        enable = 1'b1;
        model_step(ef, ew, eo);
        @(posedge clock); @(negedge clock);
        enable = 1'($urandom_range(0, 1));
        check("exec_addr", 32'(ram_address), 32'(eo));
        check("exec_wr", 32'(ram_write), 32'(0));
        @(posedge clock); @(negedge clock);
        check("flags", 32'({flag_o, flag_f, jmp, rtn}), 32'(ef));
        check("wr", 32'(ram_write), 32'(ew));
        if (ew) begin
            check("wr_addr", 32'(ram_address), 32'(eo));
            check("wr_data", 32'(ram_data_in), 32'(m_din));
            mem[ram_address] = ram_data_in;
            @(posedge clock); @(negedge clock);
            check("post_wr", 32'({ram_write, flag_o, flag_f, jmp, rtn}), 32'(0));
        end
        check("rr", 32'(rr), 32'(m_rr));
        check("din", 32'(ram_data_in), 32'(m_din));
    endtask

    initial begin
        logic seen_ff;
        for (int i = 0; i < 256; i++) begin
            prog[i] = 12'($urandom);
            set_mem(i, 1'($urandom));
        end
        reset  = 1'b0;
        enable = 1'b0;
        repeat (2) @(negedge clock);
        check("rst_pc", 32'(pc), 32'(0));
        check("rst_rr", 32'(rr), 32'(0));
        check("rst_outs", 32'({ram_write, ram_data_in, flag_o, flag_f, jmp, rtn}), 32'(0));
        check("rst_addr", 32'(ram_address), 32'(0));
        reset = 1'b1;
        model_reset();

        // Directed program: logic, enabled store, SKZ skip, JMP/RTN, oen=0 store, pc wrap.
        prog[8'h00] = 12'h600; prog[8'h01] = 12'hA01; prog[8'h02] = 12'hB01;
        prog[8'h03] = 12'h105; prog[8'h04] = 12'h802; prog[8'h05] = 12'h205;
        prog[8'h06] = 12'hE00; prog[8'h07] = 12'h802; prog[8'h08] = 12'hC10;
        prog[8'h09] = 12'h000; prog[8'h0A] = 12'hB03; prog[8'h0B] = 12'h902;
        prog[8'h0C] = 12'hCFF; prog[8'h10] = 12'hD00; prog[8'h11] = 12'h000;
        prog[8'h12] = 12'hC0A; prog[8'hFF] = 12'hF00;
        set_mem(0, 1'b0); set_mem(1, 1'b1); set_mem(2, 1'b0);
        set_mem(3, 1'b0); set_mem(5, 1'b1);
        seen_ff = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (m_pc == 8'hFF) seen_ff = 1'b1;
            run_instr();
            if (seen_ff && m_pc == 8'h00) break;
        end

        for (int i = 0; i < 256; i++) prog[i] = 12'($urandom);
        for (int i = 0; i < 300; i++) run_instr();

        // Reset asserted in the middle of a WRITE cycle.
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        model_reset();
        prog[0] = 12'h600; prog[1] = 12'hA01; prog[2] = 12'hB01; prog[3] = 12'h802;
        set_mem(0, 1'b0); set_mem(1, 1'b1);
        for (int i = 0; i < 3; i++) run_instr();
        check("mw_pc", 32'(pc), 32'(3));
        enable = 1'b1;
        @(posedge clock); @(negedge clock);
        @(posedge clock); @(negedge clock);
        check("mw_wr_high", 32'(ram_write), 32'(1));
        reset = 1'b0;
        #1;
        check("mw_wr_drop", 32'(ram_write), 32'(0));
        check("mw_pc0", 32'(pc), 32'(0));
        check("mw_rr0", 32'(rr), 32'(0));
        check("mw_addr0", 32'(ram_address), 32'(0));
        check("mw_outs0", 32'({ram_data_in, flag_o, flag_f, jmp, rtn}), 32'(0));
        @(negedge clock);
        reset = 1'b1;
        model_reset();
        for (int i = 0; i < 30; i++) run_instr();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
